dual_port_memory: RTL and testbench
===================================

DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 Parameter DATA_WIDTH, 16, word width in bits; SHALL be >= 1.
REQ-002 Parameter ADDR_WIDTH, 15, address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter WRITE_MODE, 0, write-port output policy: 0 write-first, 1 read-first, 2 no-change.
REQ-004 Parameter OUT_REG, 0, extra output pipeline stage: 0 absent, 1 present.
REQ-005 Clocking SHALL be one clock, clk; reset SHALL be asynchronous, active-low, on rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 port_a_en / port_b_en  input  1  port access request, sampled on clk rise.
REQ-009 port_a_we / port_b_we  input  1  write when en high; read when en high and we low.
REQ-010 port_a_address / port_b_address  input  ADDR_WIDTH  word address.
REQ-011 port_a_in / port_b_in  input  DATA_WIDTH  write data.
REQ-012 port_a_out / port_b_out  output  DATA_WIDTH  registered read data.
REQ-013 port_a_valid / port_b_valid  output  1  one-cycle pulse marking new data on port_x_out.
REQ-014 collision  output  1  one-cycle pulse: same-address conflict detected.
REQ-015 busy  output  1  high while the clear engine runs; constant 0 when clear is compiled out.

Function
REQ-016 Access with en low SHALL be ignored; port_x_out SHALL hold and valid SHALL stay 0.
REQ-017 Read latency SHALL be 1 + OUT_REG cycles from the sampling edge to valid/out.
REQ-018 On write: mode 0 SHALL present port_x_in; mode 1 SHALL present the prior content; mode 2 SHALL hold port_x_out and SHALL not assert valid.
REQ-019 Back-to-back accesses every cycle SHALL be accepted with no bubbles.
REQ-020 Equal addresses, both en, both we: port A data SHALL be stored and collision SHALL pulse.
REQ-021 Equal addresses, one writes, other reads: reader SHALL return the prior content and collision SHALL pulse.
REQ-022 Equal addresses, both reads: both SHALL return the content; collision SHALL stay 0.
REQ-023 collision SHALL align with the valid of the colliding accesses (same latency).
REQ-024 Address arithmetic SHALL be unsigned ADDR_WIDTH bits with no wrap logic.

Reset
REQ-025 While rst_n is low: port_x_out = 0, port_x_valid = 0, collision = 0, pipeline stages cleared.
REQ-026 Array contents SHALL be unaffected by reset unless the clear feature is compiled in.
REQ-027 Reset asserted mid-access SHALL drop in-flight reads; no valid SHALL appear for them.

Configuration
REQ-028 With MEM_RESET_CLEAR_EN defined: FSM IDLE/CLEAR; rst_n release SHALL enter CLEAR.
REQ-029 In CLEAR: one word per cycle SHALL be zeroed from address 0 upward; busy = 1; all port requests SHALL be ignored (no write, no valid).
REQ-030 CLEAR SHALL last exactly 2**ADDR_WIDTH cycles, then go to IDLE with busy = 0.
REQ-031 Reset during CLEAR SHALL restart the clear from address 0.
REQ-032 Without MEM_RESET_CLEAR_EN: no FSM or counter; busy tied 0; contents undefined after power-up.

Structure
REQ-033 Package mem_pkg SHALL hold the WRITE_MODE encodings (WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE) and clear-FSM state typedef.
REQ-034 Sub-module mem_out_stage SHALL implement the optional output register and valid/collision delay, instantiated once per port.

Verification
REQ-035 Mode 0, OUT_REG 0: A writes 0x1234 to 0x0010 -> cycle 1: port_a_out = 0x1234, port_a_valid = 1.
REQ-036 Mode 1: mem[0x0020] = 0xAAAA; A writes 0x5555 to 0x0020 -> port_a_out = 0xAAAA; B then reads 0x5555.
REQ-037 Both write 0x0030 (A 0x1111, B 0x2222) -> collision = 1; later read returns 0x1111.
REQ-038 OUT_REG 1: B reads 0x0040 (=0xBEEF) on consecutive cycles -> valid at cycles 2, 3; out = 0xBEEF.
REQ-039 MEM_RESET_CLEAR_EN, ADDR_WIDTH 4: release rst_n -> busy high 16 cycles; every address reads 0x0000.
REQ-040 rst_n pulsed low one cycle after a read request -> no valid for it; outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for dual_port_memory: write-port output policies and clear-FSM states.
package mem_pkg;

  localparam int unsigned WM_WRITE_FIRST = 0;
  localparam int unsigned WM_READ_FIRST  = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  typedef logic [0:0] clr_state_t;

  localparam clr_state_t ST_IDLE  = 1'b0;
  localparam clr_state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/dual_port_memory_if.sv
// Port A/B access bus for dual_port_memory; the memory takes the slave side.
interface dual_port_memory_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 15
);
  logic                  port_a_en;
  logic                  port_a_we;
  logic [ADDR_WIDTH-1:0] port_a_address;
  logic [DATA_WIDTH-1:0] port_a_in;
  logic [DATA_WIDTH-1:0] port_a_out;
  logic                  port_a_valid;
  logic                  port_b_en;
  logic                  port_b_we;
  logic [ADDR_WIDTH-1:0] port_b_address;
  logic [DATA_WIDTH-1:0] port_b_in;
  logic [DATA_WIDTH-1:0] port_b_out;
  logic                  port_b_valid;
  logic                  collision;
  logic                  busy;

  modport master (
    output port_a_en, port_a_we, port_a_address, port_a_in,
    output port_b_en, port_b_we, port_b_address, port_b_in,
    input  port_a_out, port_a_valid, port_b_out, port_b_valid, collision, busy
  );

  modport slave (
    input  port_a_en, port_a_we, port_a_address, port_a_in,
    input  port_b_en, port_b_we, port_b_address, port_b_in,
    output port_a_out, port_a_valid, port_b_out, port_b_valid, collision, busy
  );
endinterface

// File: rtl/mem_out_stage.sv
// Per-port read-data register plus optional second pipeline stage; valid and
// collision travel with the data so they stay aligned.
module mem_out_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_coll,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_coll
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_coll;

  // Data only loads on valid so the output holds across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_coll  <= i_coll;
      if (i_valid) r_data <= i_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_data2;
      logic                  r_valid2;
      logic                  r_coll2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data2  <= '0;
          r_valid2 <= 1'b0;
          r_coll2  <= 1'b0;
        end else begin
          r_valid2 <= r_valid;
          r_coll2  <= r_coll;
          if (r_valid) r_data2 <= r_data;
        end
      end

      assign o_data  = r_data2;
      assign o_valid = r_valid2;
      assign o_coll  = r_coll2;
    end else begin : g_no_out_reg
      assign o_data  = r_data;
      assign o_valid = r_valid;
      assign o_coll  = r_coll;
    end
  endgenerate

endmodule

// File: rtl/dual_port_memory.sv
// True dual-port RAM with configurable write-port output policy and output register.
// Define MEM_RESET_CLEAR_EN to zero the array after every reset release.
module dual_port_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned WRITE_MODE = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input logic               clk,
  input logic               rst_n,
  dual_port_memory_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;

`ifdef MEM_RESET_CLEAR_EN
  clr_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (r_clr_addr == {ADDR_WIDTH{1'b1}}) r_state <= ST_IDLE;
    end
  end

  assign w_busy     = (r_state == ST_CLEAR);
  assign w_clr_we   = w_busy;
  assign w_clr_addr = r_clr_addr;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  logic                  w_a_acc, w_b_acc, w_a_wr, w_b_wr, w_a_vld, w_b_vld, w_coll;
  logic [DATA_WIDTH-1:0] w_a_data, w_b_data;
  logic                  w_a_coll, w_b_coll;

  assign w_a_acc = bus.port_a_en & ~w_busy;
  assign w_b_acc = bus.port_b_en & ~w_busy;
  assign w_a_wr  = w_a_acc & bus.port_a_we;
  assign w_b_wr  = w_b_acc & bus.port_b_we;

  assign w_a_vld = w_a_acc & (~bus.port_a_we | (WRITE_MODE != WM_NO_CHANGE));
  assign w_b_vld = w_b_acc & (~bus.port_b_we | (WRITE_MODE != WM_NO_CHANGE));

  // Array reads see pre-edge content, so a reader colliding with a writer gets old data.
  assign w_a_data = (bus.port_a_we && (WRITE_MODE == WM_WRITE_FIRST)) ? bus.port_a_in
                                                                      : r_mem[bus.port_a_address];
  assign w_b_data = (bus.port_b_we && (WRITE_MODE == WM_WRITE_FIRST)) ? bus.port_b_in
                                                                      : r_mem[bus.port_b_address];

  assign w_coll = w_a_acc & w_b_acc & (bus.port_a_address == bus.port_b_address) &
                  (bus.port_a_we | bus.port_b_we);

  // Port A is written last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    if (w_b_wr)   r_mem[bus.port_b_address] <= bus.port_b_in;
    if (w_a_wr)   r_mem[bus.port_a_address] <= bus.port_a_in;
  end

  mem_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_out_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (w_a_data),
    .i_valid (w_a_vld),
    .i_coll  (w_coll),
    .o_data  (bus.port_a_out),
    .o_valid (bus.port_a_valid),
    .o_coll  (w_a_coll)
  );

  mem_out_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_out_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (w_b_data),
    .i_valid (w_b_vld),
    .i_coll  (w_coll),
    .o_data  (bus.port_b_out),
    .o_valid (bus.port_b_valid),
    .o_coll  (w_b_coll)
  );

  assign bus.collision = w_a_coll | w_b_coll;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_dual_port_memory.sv
// Scoreboard bench: three memories (write-first, read-first, no-change + output register)
// share one stimulus stream; a monitor pops expected responses as valids appear.
module tb_dual_port_memory;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          ae = 0, awe = 0, be = 0, bwe = 0;
  logic [AW-1:0] aa = '0, ba = '0;
  logic [DW-1:0] ad = '0, bd = '0;

  logic          vld [6];
  logic [DW-1:0] dat [6];
  logic          col [3];
  logic          bsy [3];
  logic          busy_any;

  dual_port_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].port_a_en      = ae;
    assign bus[g].port_a_we      = awe;
    assign bus[g].port_a_address = aa;
    assign bus[g].port_a_in      = ad;
    assign bus[g].port_b_en      = be;
    assign bus[g].port_b_we      = bwe;
    assign bus[g].port_b_address = ba;
    assign bus[g].port_b_in      = bd;
    assign vld[2*g]   = bus[g].port_a_valid;
    assign vld[2*g+1] = bus[g].port_b_valid;
    assign dat[2*g]   = bus[g].port_a_out;
    assign dat[2*g+1] = bus[g].port_b_out;
    assign col[g]     = bus[g].collision;
    assign bsy[g]     = bus[g].busy;
  end
  assign busy_any = bsy[0] | bsy[1] | bsy[2];

  dual_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(0), .OUT_REG(0)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus[0]));
  dual_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(1), .OUT_REG(0)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus[1]));
  dual_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(2), .OUT_REG(1)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .bus (bus[2]));

  typedef struct {
    logic [DW-1:0] d;
    logic          c;
    logic          chk;
    int            cyc;
  } sb_t;

  sb_t sb [6][$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // q = 2*dut + port (0=A, 1=B); dut2 has one extra cycle of latency.
  task automatic push(input int q, input logic [DW-1:0] d, input logic c, input logic chk);
    sb_t e;
    e.d   = d;
    e.c   = c;
    e.chk = chk;
    e.cyc = cyc + 1 + ((q >= 4) ? 1 : 0);
    sb[q].push_back(e);
  endtask

  task automatic drive(input logic i_ae, input logic i_awe, input logic [AW-1:0] i_aa,
                       input logic [DW-1:0] i_ad, input logic i_be, input logic i_bwe,
                       input logic [AW-1:0] i_ba, input logic [DW-1:0] i_bd);
    @(negedge clk);
    ae = i_ae; awe = i_awe; aa = i_aa; ad = i_ad;
    be = i_be; bwe = i_bwe; ba = i_ba; bd = i_bd;
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (vld[i]) begin
          if (sb[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid q%0d: got valid with data %h, required no valid",
                     i, dat[i]);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("q%0d latency", i), cyc, e.cyc);
            if (e.chk) check($sformatf("q%0d data", i), {16'h0, dat[i]}, {16'h0, e.d});
            check($sformatf("q%0d collision", i), {31'h0, col[i/2]}, {31'h0, e.c});
          end
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_any && n < 2000) begin
      n++;
      @(negedge clk);
    end
`ifdef MEM_RESET_CLEAR_EN
    check("clear busy cycles", n, 256);
`else
    check("busy tied low", n, 0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s q%0d out", tag, i), {16'h0, dat[i]}, 32'h0);
      check($sformatf("%s q%0d valid", tag, i), {31'h0, vld[i]}, 32'h0);
    end
    for (int k = 0; k < 3; k++) check($sformatf("%s d%0d coll", tag, k), {31'h0, col[k]}, 32'h0);
  endtask

  logic [DW-1:0] fin_a, fin_b;

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_idle();

    // Preload; read-first results on unknown prior content are timing-only.
    drive(1, 1, 8'h10, 16'h1234, 1, 1, 8'h20, 16'hAAAA);
    push(0, 16'h1234, 0, 1); push(1, 16'hAAAA, 0, 1); push(2, '0, 0, 0); push(3, '0, 0, 0);
    drive(1, 1, 8'h40, 16'hBEEF, 1, 1, 8'h50, 16'h0F0F);
    push(0, 16'hBEEF, 0, 1); push(1, 16'h0F0F, 0, 1); push(2, '0, 0, 0); push(3, '0, 0, 0);
    drive(1, 1, 8'h20, 16'h5555, 0, 0, 8'h00, 16'h0000);
    push(0, 16'h5555, 0, 1); push(2, 16'hAAAA, 0, 1);
    drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 16'h0000);
    push(1, 16'h5555, 0, 1); push(3, 16'h5555, 0, 1); push(5, 16'h5555, 0, 1);
    // Both write 0x30: A wins.
    drive(1, 1, 8'h30, 16'h1111, 1, 1, 8'h30, 16'h2222);
    push(0, 16'h1111, 1, 1); push(1, 16'h2222, 1, 1); push(2, '0, 1, 0); push(3, '0, 1, 0);
    drive(1, 0, 8'h30, 16'h0000, 1, 0, 8'h30, 16'h0000);
    for (int q = 0; q < 6; q++) push(q, 16'h1111, 0, 1);
    // A writes while B reads the same word: B sees prior content.
    drive(1, 1, 8'h40, 16'hCAFE, 1, 0, 8'h40, 16'h0000);
    push(0, 16'hCAFE, 1, 1); push(1, 16'hBEEF, 1, 1); push(2, 16'hBEEF, 1, 1);
    push(3, 16'hBEEF, 1, 1); push(5, 16'hBEEF, 1, 1);
    drive(1, 1, 8'h40, 16'hBEEF, 1, 0, 8'h40, 16'h0000);
    push(0, 16'hBEEF, 1, 1); push(1, 16'hCAFE, 1, 1); push(2, 16'hCAFE, 1, 1);
    push(3, 16'hCAFE, 1, 1); push(5, 16'hCAFE, 1, 1);
    repeat (2) begin
      drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'h40, 16'h0000);
      push(1, 16'hBEEF, 0, 1); push(3, 16'hBEEF, 0, 1); push(5, 16'hBEEF, 0, 1);
    end
    drive(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
    check("hold d0 A out", {16'h0, dat[0]}, 32'h0000BEEF);
    check("hold d1 A out", {16'h0, dat[2]}, 32'h0000CAFE);
    check("no-change d2 A out", {16'h0, dat[4]}, 32'h00001111);

    // Reset lands while a read is in flight: nothing may emerge.
    drive(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    ae = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle();

`ifdef MEM_RESET_CLEAR_EN
    fin_a = 16'h0000;
    fin_b = 16'h0000;
`else
    fin_a = 16'h1111;
    fin_b = 16'h5555;
`endif
    drive(1, 0, 8'h30, 16'h0000, 1, 0, 8'h20, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      push(2*k, fin_a, 0, 1);
      push(2*k+1, fin_b, 0, 1);
    end
    drive(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    repeat (4) @(negedge clk);
    for (int q = 0; q < 6; q++) check($sformatf("q%0d drained", q), sb[q].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
